// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the regfile writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultAddrW = 5;

  // r0 is hard-wired to zero; writes to it are dropped.
  localparam int unsigned RegZero = 0;

  typedef enum logic {
    PortA = 1'b0,
    PortB = 1'b1
  } port_e;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO for one writeback source. Exposes every slot's address and
// valid bit so the top can compare read operands against all queued writes.
module regfile_wb_arbiter_wb_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned AddrW = 5,
  parameter int unsigned DataW = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push_i,
  input  logic [AddrW-1:0]            push_addr_i,
  input  logic [DataW-1:0]            push_data_i,
  input  logic                        pop_i,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [AddrW-1:0]            head_addr_o,
  output logic [DataW-1:0]            head_data_o,
  output logic [Depth-1:0][AddrW-1:0] entry_addr_o,
  output logic [Depth-1:0]            entry_valid_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrW:0]              wptr_q, wptr_d;
  logic [PtrW:0]              rptr_q, rptr_d;
  logic [Depth-1:0][AddrW-1:0] addr_q, addr_d;
  logic [Depth-1:0][DataW-1:0] data_q, data_d;
  logic [Depth-1:0]           valid_q, valid_d;
  logic                       push_en, pop_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);

  // Never accept into a full FIFO, even if it pops this cycle.
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  assign head_addr_o   = addr_q[rptr_q[PtrW-1:0]];
  assign head_data_o   = data_q[rptr_q[PtrW-1:0]];
  assign entry_addr_o  = addr_q;
  assign entry_valid_o = valid_q;

  // Next-state for storage, per-slot valid bits and pointers.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (pop_en) begin
      valid_d[rptr_q[PtrW-1:0]] = 1'b0;
      rptr_d                    = rptr_q + 1'b1;
    end
    if (push_en) begin
      addr_d[wptr_q[PtrW-1:0]]  = push_addr_i;
      data_d[wptr_q[PtrW-1:0]]  = push_data_i;
      valid_d[wptr_q[PtrW-1:0]] = 1'b1;
      wptr_d                    = wptr_q + 1'b1;
    end
  end

  // FIFO state register; reset discards all queued entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between the ALU (A) and LSU (B) writeback sources.
// Each source is queued; a round-robin arbiter drains one head per cycle, and read
// operands matching any queued write are flagged so decode can stall.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned DataW     = DefaultDataW,
  parameter int unsigned AddrW     = DefaultAddrW,
  parameter int unsigned FifoDepth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             a_valid_i,
  output logic             a_ready_o,
  input  logic [AddrW-1:0] a_addr_i,
  input  logic [DataW-1:0] a_data_i,
  input  logic             b_valid_i,
  output logic             b_ready_o,
  input  logic [AddrW-1:0] b_addr_i,
  input  logic [DataW-1:0] b_data_i,
  output logic             we_o,
  output logic [AddrW-1:0] waddr_o,
  output logic [DataW-1:0] wdata_o,
  input  logic [AddrW-1:0] raddr1_i,
  input  logic [AddrW-1:0] raddr2_i,
  output logic             hazard1_o,
  output logic             hazard2_o,
  output logic             busy_o
);

  logic                            a_full, a_empty, b_full, b_empty;
  logic [AddrW-1:0]                a_head_addr, b_head_addr;
  logic [DataW-1:0]                a_head_data, b_head_data;
  logic [FifoDepth-1:0][AddrW-1:0] a_entry_addr, b_entry_addr;
  logic [FifoDepth-1:0]            a_entry_valid, b_entry_valid;
  logic                            grant_a, grant_b;
  port_e                           rr_q, rr_d;

  assign a_ready_o = !a_full;
  assign b_ready_o = !b_full;
  assign busy_o    = !a_empty || !b_empty;

  regfile_wb_arbiter_wb_fifo #(
    .Depth (FifoDepth),
    .AddrW (AddrW),
    .DataW (DataW)
  ) u_fifo_a (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (a_valid_i),
    .push_addr_i   (a_addr_i),
    .push_data_i   (a_data_i),
    .pop_i         (grant_a),
    .full_o        (a_full),
    .empty_o       (a_empty),
    .head_addr_o   (a_head_addr),
    .head_data_o   (a_head_data),
    .entry_addr_o  (a_entry_addr),
    .entry_valid_o (a_entry_valid)
  );

  regfile_wb_arbiter_wb_fifo #(
    .Depth (FifoDepth),
    .AddrW (AddrW),
    .DataW (DataW)
  ) u_fifo_b (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (b_valid_i),
    .push_addr_i   (b_addr_i),
    .push_data_i   (b_data_i),
    .pop_i         (grant_b),
    .full_o        (b_full),
    .empty_o       (b_empty),
    .head_addr_o   (b_head_addr),
    .head_data_o   (b_head_data),
    .entry_addr_o  (b_entry_addr),
    .entry_valid_o (b_entry_valid)
  );

  // Round-robin grant and write-port mux; idle port drives zeros, not a stale head.
  always_comb begin
    grant_a = !a_empty && (b_empty || (rr_q == PortA));
    grant_b = !b_empty && !grant_a;
    rr_d    = rr_q;
    // Pointer only moves when both sides actually contended.
    if (!a_empty && !b_empty) begin
      rr_d = grant_a ? PortB : PortA;
    end
    we_o    = 1'b0;
    waddr_o = '0;
    wdata_o = '0;
    if (grant_a) begin
      waddr_o = a_head_addr;
      wdata_o = a_head_data;
      we_o    = (a_head_addr != AddrW'(RegZero));
    end else if (grant_b) begin
      waddr_o = b_head_addr;
      wdata_o = b_head_data;
      we_o    = (b_head_addr != AddrW'(RegZero));
    end
  end

  // Operand hazards include the head being written now: the regfile has no bypass.
  always_comb begin
    hazard1_o = 1'b0;
    hazard2_o = 1'b0;
    for (int i = 0; i < int'(FifoDepth); i++) begin
      if (a_entry_valid[i] && (a_entry_addr[i] == raddr1_i)) hazard1_o = 1'b1;
      if (b_entry_valid[i] && (b_entry_addr[i] == raddr1_i)) hazard1_o = 1'b1;
      if (a_entry_valid[i] && (a_entry_addr[i] == raddr2_i)) hazard2_o = 1'b1;
      if (b_entry_valid[i] && (b_entry_addr[i] == raddr2_i)) hazard2_o = 1'b1;
    end
    if (raddr1_i == AddrW'(RegZero)) hazard1_o = 1'b0;
    if (raddr2_i == AddrW'(RegZero)) hazard2_o = 1'b0;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= PortA;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: queue-based reference model of the two writeback FIFOs and
// round-robin arbitration, plus a regfile shadow written from the DUT's write port.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 2;
  localparam logic [DW-1:0] MARK = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [AW-1:0] a_addr, b_addr, waddr, raddr1, raddr2;
  logic [DW-1:0] a_data, b_data, wdata;
  logic          we, hazard1, hazard2, busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DataW     (DW),
    .AddrW     (AW),
    .FifoDepth (DEPTH)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .a_valid_i (a_valid),
    .a_ready_o (a_ready),
    .a_addr_i  (a_addr),
    .a_data_i  (a_data),
    .b_valid_i (b_valid),
    .b_ready_o (b_ready),
    .b_addr_i  (b_addr),
    .b_data_i  (b_data),
    .we_o      (we),
    .waddr_o   (waddr),
    .wdata_o   (wdata),
    .raddr1_i  (raddr1),
    .raddr2_i  (raddr2),
    .hazard1_o (hazard1),
    .hazard2_o (hazard2),
    .busy_o    (busy)
  );

  // Shadow regfile driven by the DUT's write port.
  logic [DW-1:0] dut_rf [0:31] = '{default: '0};
  always @(posedge clk) if (we) dut_rf[waddr] <= wdata;

  // Reference model state.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  ent_t          qa[$];
  ent_t          qb[$];
  bit            b_turn;  // set when B wins the next contended cycle
  logic [DW-1:0] ref_rf [0:31] = '{default: '0};

  int total = 0;
  int bad   = 0;

  logic          e_we, e_h1, e_h2, e_busy, e_ar, e_br;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata;

  function automatic bit queued(input logic [AW-1:0] r);
    if (r == 0) return 1'b0;
    foreach (qa[i]) if (qa[i].a == r) return 1'b1;
    foreach (qb[i]) if (qb[i].a == r) return 1'b1;
    return 1'b0;
  endfunction

  // 0: nobody, 1: A, 2: B
  function automatic int pick();
    if (qa.size() != 0 && (qb.size() == 0 || !b_turn)) return 1;
    if (qb.size() != 0) return 2;
    return 0;
  endfunction

  function automatic void model_expect();
    ent_t h;
    int   g;
    g       = pick();
    e_we    = 1'b0;
    e_waddr = '0;
    e_wdata = '0;
    if (g != 0) begin
      h       = (g == 1) ? qa[0] : qb[0];
      e_waddr = h.a;
      e_wdata = h.d;
      e_we    = (h.a != 0);
    end
    e_h1   = queued(raddr1);
    e_h2   = queued(raddr2);
    e_busy = (qa.size() + qb.size()) != 0;
    e_ar   = qa.size() < DEPTH;
    e_br   = qb.size() < DEPTH;
  endfunction

  function automatic logic [42:0] obs_vec();
    return {we, waddr, wdata, hazard1, hazard2, busy, a_ready, b_ready};
  endfunction

  function automatic logic [42:0] exp_vec();
    return {e_we, e_waddr, e_wdata, e_h1, e_h2, e_busy, e_ar, e_br};
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic tick();
    int   g;
    bit   pa, pb, both;
    ent_t w;
    g    = pick();
    pa   = a_valid && (qa.size() < DEPTH);
    pb   = b_valid && (qb.size() < DEPTH);
    both = (qa.size() != 0) && (qb.size() != 0);
    @(posedge clk);
    if (g == 1) w = qa.pop_front();
    if (g == 2) w = qb.pop_front();
    if (g != 0 && w.a != 0) ref_rf[w.a] = w.d;
    if (both) b_turn = (g == 1);
    if (pa) qa.push_back({a_addr, a_data});
    if (pb) qb.push_back({b_addr, b_data});
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    raddr1  = '0;   raddr2 = '0;
  endtask

  task automatic test_reset();
    raddr1 = 5'd3;
    raddr2 = 5'd4;
    #1;
    total++;
    if (we !== 1'b0 || waddr !== '0 || wdata !== '0) begin
      bad++; $display("FAIL reset_wport: got we=%b waddr=%0d wdata=%0h want 0/0/0", we, waddr, wdata);
    end
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got a=%b b=%b want 1/1", a_ready, b_ready);
    end
    total++;
    if (busy !== 1'b0 || hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
      bad++; $display("FAIL reset_flags: got busy=%b h1=%b h2=%b want 0", busy, hazard1, hazard2);
    end
  endtask

  task automatic test_single();
    a_valid = 1'b1; a_addr = 5'd19; a_data = 32'd123456; raddr1 = 5'd19;
    @(negedge clk);
    total++;
    if (hazard1 !== 1'b0) begin
      bad++; $display("FAIL single_h1_before: got %b want 0", hazard1);
    end
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    total++;
    if (we !== 1'b1 || waddr !== 5'd19 || wdata !== 32'd123456 || hazard1 !== 1'b1) begin
      bad++; $display("FAIL single_write: got we=%b waddr=%0d wdata=%0d h1=%b want 1/19/123456/1",
                      we, waddr, wdata, hazard1);
    end
    tick();
    @(negedge clk);
    total++;
    if (we !== 1'b0 || hazard1 !== 1'b0 || dut_rf[19] !== 32'd123456) begin
      bad++; $display("FAIL single_after: got we=%b h1=%b r19=%0d want 0/0/123456",
                      we, hazard1, dut_rf[19]);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [AW-1:0] order[$];
    logic [AW-1:0] want [4];
    want = '{5'd1, 5'd3, 5'd2, 5'd4};
    for (int c = 0; c < 7; c++) begin
      a_valid = (c < 2); a_addr = (c == 0) ? 5'd1 : 5'd2; a_data = 32'h100 + c;
      b_valid = (c < 2); b_addr = (c == 0) ? 5'd3 : 5'd4; b_data = 32'h200 + c;
      raddr1  = 5'd2;    raddr2 = 5'd4;
      @(negedge clk);
      model_expect();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL contention_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (we) order.push_back(waddr);
      tick();
    end
    total++;
    if (order.size() != 4 || order[0] !== want[0] || order[1] !== want[1] ||
        order[2] !== want[2] || order[3] !== want[3]) begin
      bad++; $display("FAIL contention_order: got %p want %p", order, want);
    end
    idle_inputs();
  endtask

  task automatic test_full();
    bit marked = 1'b0;
    bit seen   = 1'b0;
    for (int c = 0; c < 16; c++) begin
      a_valid = (c < 8); a_addr = 5'(8 + c); a_data = 32'h300 + c;
      b_valid = (c < 8); b_addr = 5'(20 + (c % 8)); b_data = 32'h400 + c;
      @(negedge clk);
      model_expect();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL full_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (we && wdata === MARK) seen = 1'b1;
      if (!marked && !e_br && c < 8) begin
        marked = 1'b1;
        b_data = MARK;
        total++;
        if (b_ready !== 1'b0) begin
          bad++; $display("FAIL full_ready: got b_ready=%b want 0", b_ready);
        end
      end
      tick();
    end
    total++;
    if (!marked || seen) begin
      bad++; $display("FAIL full_reject: full reached=%b marker written=%b want 1/0", marked, seen);
    end
    idle_inputs();
  endtask

  task automatic test_r0();
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'd233; raddr1 = 5'd0;
    @(negedge clk);
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    total++;
    if (we !== 1'b0 || busy !== 1'b1 || hazard1 !== 1'b0 || wdata !== 32'd233) begin
      bad++; $display("FAIL r0_grant: got we=%b busy=%b h1=%b wdata=%0d want 0/1/0/233",
                      we, busy, hazard1, wdata);
    end
    tick();
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || dut_rf[0] !== '0) begin
      bad++; $display("FAIL r0_after: got busy=%b r0=%0d want 0/0", busy, dut_rf[0]);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_throughput();
    for (int c = 0; c < 10; c++) begin
      a_valid = 1'b1; a_addr = 5'(1 + c); a_data = $urandom;
      @(negedge clk);
      model_expect();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL tput_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c > 0) begin
        total++;
        if (we !== 1'b1 || a_ready !== 1'b1 || busy !== 1'b1) begin
          bad++; $display("FAIL tput_stream%0d: got we=%b a_ready=%b busy=%b want 1/1/1",
                          c, we, a_ready, busy);
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      a_valid = ($urandom_range(0, 3) != 0); a_addr = 5'($urandom_range(0, 7)); a_data = $urandom;
      b_valid = ($urandom_range(0, 2) != 0); b_addr = 5'($urandom_range(0, 7)); b_data = $urandom;
      raddr1  = 5'($urandom_range(0, 7));    raddr2 = 5'($urandom_range(0, 7));
      @(negedge clk);
      model_expect();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      tick();
    end
    for (int r = 0; r < 32; r++) begin
      total++;
      if (dut_rf[r] !== ref_rf[r]) begin
        bad++; $display("FAIL random_rf r%0d: got %h want %h", r, dut_rf[r], ref_rf[r]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 4; c++) begin
      a_valid = 1'b1; a_addr = 5'(10 + c); a_data = 32'h500 + c;
      b_valid = 1'b1; b_addr = 5'(14 + c); b_data = 32'h600 + c;
      @(negedge clk);
      tick();
    end
    idle_inputs();
    raddr1 = qa[0].a;
    raddr2 = qb[0].a;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (we !== 1'b0 || busy !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b1 ||
        hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
      bad++; $display("FAIL reset_mid: got we=%b busy=%b ar=%b br=%b h1=%b h2=%b want 0/0/1/1/0/0",
                      we, busy, a_ready, b_ready, hazard1, hazard2);
    end
    qa.delete();
    qb.delete();
    b_turn = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      model_expect();
      total++;
      if (we !== 1'b0 || obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_release%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    b_turn = 1'b0;
    rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    rst_n = 1'b1;
    idle_inputs();
    test_single();
    test_contention();
    test_full();
    test_r0();
    test_throughput();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tick();
    end
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
